vga_digit_decoder: RTL and testbench
====================================

VGA_DIGIT_DECODER -- requirements
Module: vga_digit_decoder

Interface
REQ-001 SHALL have port: clk  input  1  pixel clock, one pixel per cycle, all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: h_sync, v_sync  input  1 each  active-high syncs from the display block.
REQ-004 SHALL have ports: r, g, b  input  1 each  pixel colour.
REQ-005 SHALL have port: num_data  output  44  decoded digits; digit d (0 = leftmost) in [4d+:4].
REQ-006 SHALL have port: num_valid  output  1  one-cycle pulse when num_data updates.
REQ-007 SHALL have port: locked  output  1  high while timing is tracked.
REQ-008 SHALL have ports: sync_err, decode_err  output  1 each  one-cycle error pulses.

Function
REQ-009 SHALL assume timing: 800 clocks/line (col 0..799), 524 lines/frame (row 0..523); h_sync high for col 656..751; v_sync high for rows 491..492; v_sync rises at col 0.
REQ-010 SHALL implement states SEARCH, ACQUIRE, TRACK.
REQ-011 SEARCH: on v_sync rising edge, load row=491, col=0, go to ACQUIRE.
REQ-012 ACQUIRE/TRACK: col increments each cycle, wraps 799->0 with row increment; row wraps 523->0.
REQ-013 ACQUIRE->TRACK and locked=1 on the next v_sync rising edge coinciding with row=491, col=0.
REQ-014 Sync check: an h_sync rising edge at col!=656, h_sync high outside 656..751, or a v_sync rising edge not at row=491/col=0 SHALL pulse sync_err, clear locked, return to SEARCH.
REQ-015 r/g/b lag h_sync by one clock: sample at counter (c+1, y) belongs to pixel (c, y).
REQ-016 Pixel lit SHALL be r&g&b.
REQ-017 Cell centres: col = 75+40d+10x, row = 105+10y; d 0..10, x 0..3, y 0..4; sample bit index x+4y of digit d's 20-bit register.
REQ-018 Codes SHALL be 0..10, glyph patterns G_0..G_10 held in a localparam table equal to the 20 cell values the display block emits per code (code 10 = separator).
REQ-019 Exact match only; no match SHALL yield code 4'hF and assert decode_err at the update point.
REQ-020 Update point SHALL be row=150, col=0: in TRACK only, num_data loads all 11 codes and num_valid pulses for 1 cycle.
REQ-021 No update in SEARCH/ACQUIRE; a frame with sync_err before the update point SHALL produce no update.
REQ-022 sync_err and decode_err in the same cycle SHALL both assert.

Reset
REQ-023 rst_n low SHALL asynchronously force state SEARCH, counters 0, num_data 0, num_valid/locked/sync_err/decode_err 0, sample registers 0.
REQ-024 Reset release mid-frame SHALL resume in SEARCH; first num_valid no earlier than second v_sync rising edge.

Configuration
REQ-025 Macro VGA_DEC_STABLE_FILTER_EN, when defined, SHALL gate updates: num_data loads and num_valid pulses only if this frame's 11 codes equal the previous frame's and contain no 4'hF; decode_err unchanged.
REQ-026 Without VGA_DEC_STABLE_FILTER_EN, every TRACK frame SHALL update per REQ-020, including 4'hF codes.

Verification
REQ-027 Display block driven with 44'h0123456789A, reset released at row 0 -> locked at 2nd v_sync rise, num_data=44'h0123456789A, num_valid at row 150/col 0 (2nd frame with filter, 1st TRACK frame without).
REQ-028 h_sync shifted +3 clocks at row 200 -> sync_err 1 cycle, locked=0, no update next frame, relock after two v_sync edges.
REQ-029 Force r=0 at pixel (75,105) for digit 0 -> num_data[3:0]=4'hF, decode_err pulse, no num_valid with filter macro.
REQ-030 rst_n low at row 120/col 300 for 5 cycles -> all outputs 0 immediately, no num_valid until second frame after release.
REQ-031 num_data toggled 44'h0 / 44'h11111111111 each frame -> filter defined: no num_valid; undefined: num_valid every frame with matching value.
REQ-032 b held 0 with r=g=1 across digit region -> all codes 4'hF, decode_err each frame.

Source files
------------

// File: rtl/vga_digit_decoder.sv
// Recovers the 11-digit readout that the display block draws into its VGA stream.
// Optional VGA_DEC_STABLE_FILTER_EN: publish only codes that repeat over two frames and decode cleanly.
module vga_digit_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        r,
  input  logic        g,
  input  logic        b,
  output logic [43:0] num_data,
  output logic        num_valid,
  output logic        locked,
  output logic        sync_err,
  output logic        decode_err
);
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 524;
  localparam int HS_START = 656;
  localparam int HS_END   = 751;
  localparam int VS_ROW   = 491;
  localparam int UPD_ROW  = 150;
  localparam int N_DIG    = 11;
  localparam int N_CODE   = 11;

  // Cell bit x+4y; each hex nibble is one glyph row (y4 leftmost), bit x = column x.
  localparam logic [19:0] GLYPH [N_CODE] = '{
    20'hF999F, 20'h72226, 20'hF1F8F, 20'hF8F8F, 20'h88F99, 20'hF8F1F,
    20'hF9F1F, 20'h8888F, 20'hF9F9F, 20'hF8F9F, 20'h06060
  };

  typedef enum logic [1:0] {SEARCH, ACQUIRE, TRACK} state_t;

  state_t      state;
  logic [9:0]  col, row, col_nx, row_nx;
  logic        h_q, v_q;
  logic [19:0] cells [N_DIG];
  logic        h_rise, v_rise, sync_bad, at_update;
  logic        col_hit, row_hit, any_bad;
  logic [3:0]  samp_d;
  logic [1:0]  samp_x;
  logic [2:0]  samp_y;
  logic [43:0] codes;
`ifdef VGA_DEC_STABLE_FILTER_EN
  logic [43:0] prev_codes;
  logic        prev_ok;
`endif

  assign h_rise    = h_sync & ~h_q;
  assign v_rise    = v_sync & ~v_q;
  assign at_update = (state == TRACK) && (row == 10'(UPD_ROW)) && (col == '0);
  assign sync_bad  = (state != SEARCH) &&
                     ((h_rise && col != 10'(HS_START)) ||
                      (h_sync && (col < 10'(HS_START) || col > 10'(HS_END))) ||
                      (v_rise && !(row == 10'(VS_ROW) && col == '0)));

  // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    col_nx = col + 10'd1;
    row_nx = row;
    if (col == 10'(H_TOTAL - 1)) begin
      col_nx = '0;
      row_nx = (row == 10'(V_TOTAL - 1)) ? '0 : row + 10'd1;
    end
  end

  // Colour lags sync by one clock, so cell centre column c is seen at counter c+1.
  always_comb begin
    col_hit = 1'b0;
    row_hit = 1'b0;
    samp_d  = '0;
    samp_x  = '0;
    samp_y  = '0;
    for (int d = 0; d < N_DIG; d++)
      for (int x = 0; x < 4; x++)
        if (col == 10'(76 + 40 * d + 10 * x)) begin
          col_hit = 1'b1;
          samp_d  = 4'(d);
          samp_x  = 2'(x);
        end
    for (int y = 0; y < 5; y++)
      if (row == 10'(105 + 10 * y)) begin
        row_hit = 1'b1;
        samp_y  = 3'(y);
      end
  end

  always_comb begin
    codes   = '0;
    any_bad = 1'b0;
    for (int d = 0; d < N_DIG; d++) begin
      codes[4*d +: 4] = 4'hF;
      for (int k = 0; k < N_CODE; k++)
        if (cells[d] == GLYPH[k]) codes[4*d +: 4] = 4'(k);
      if (codes[4*d +: 4] == 4'hF) any_bad = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      col        <= '0;
      row        <= '0;
      h_q        <= 1'b0;
      v_q        <= 1'b0;
      num_data   <= '0;
      num_valid  <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      decode_err <= 1'b0;
      // NOTE: the cell store is a small flop array, not RAM, so it is cleared with everything else.
      for (int d = 0; d < N_DIG; d++) cells[d] <= '0;
`ifdef VGA_DEC_STABLE_FILTER_EN
      prev_codes <= '0;
      prev_ok    <= 1'b0;
`endif
    end else begin
      h_q        <= h_sync;
      v_q        <= v_sync;
      num_valid  <= 1'b0;
      sync_err   <= sync_bad;
      decode_err <= at_update && any_bad;
      if (state != SEARCH && col_hit && row_hit)
        cells[samp_d][{samp_y, samp_x}] <= r & g & b;
      if (sync_bad) begin
        state  <= SEARCH;
        locked <= 1'b0;
        col    <= '0;
        row    <= '0;
`ifdef VGA_DEC_STABLE_FILTER_EN
        prev_ok <= 1'b0;
`endif
      end else begin
        unique case (state)
          // Counters name the pixel on the inputs; the edge cycle is (491,0), so the next is col 1.
          SEARCH: if (v_rise) begin
            state <= ACQUIRE;
            col   <= 10'd1;
            row   <= 10'(VS_ROW);
          end
          ACQUIRE: begin
            col <= col_nx;
            row <= row_nx;
            if (v_rise) begin
              state  <= TRACK;
              locked <= 1'b1;
            end
          end
          TRACK: begin
            col <= col_nx;
            row <= row_nx;
            if (at_update) begin
`ifdef VGA_DEC_STABLE_FILTER_EN
              if (prev_ok && codes == prev_codes && !any_bad) begin
                num_data  <= codes;
                num_valid <= 1'b1;
              end
              prev_codes <= codes;
              prev_ok    <= 1'b1;
`else
              num_data  <= codes;
              num_valid <= 1'b1;
`endif
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_digit_decoder.sv
// Drives a behavioural display stream frame by frame and checks the decoder against a frame-level model.
module tb_vga_digit_decoder;
  logic        clk = 1'b0;
  logic        rst_n, h_sync, v_sync, r, g, b;
  logic [43:0] num_data;
  logic        num_valid, locked, sync_err, decode_err;

  always #5 clk = ~clk;

  vga_digit_decoder dut (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
    .r(r), .g(g), .b(b), .num_data(num_data), .num_valid(num_valid),
    .locked(locked), .sync_err(sync_err), .decode_err(decode_err)
  );

  localparam logic [19:0] GLYPH [11] = '{
    20'hF999F, 20'h72226, 20'hF1F8F, 20'hF8F8F, 20'h88F99, 20'hF8F1F,
    20'hF9F1F, 20'h8888F, 20'hF9F9F, 20'hF8F9F, 20'h06060
  };

  typedef enum {F_NONE, F_SHIFT, F_CORRUPT, F_BZERO, F_RESET} fault_e;
  typedef struct {
    logic [43:0] codes;
    bit          rnd;
    bit          same;
    fault_e      fault;
    int          v_nf;
    int          v_f;
    int          n_serr;
    int          n_derr;
  } frame_t;

  frame_t      tbl [12];
  int          total = 0, bad = 0;
  int          pc, pr, fi, rst_hold;
  fault_e      cur_fault;
  logic [43:0] cur_codes, frame_exp, exp_data, prev_codes;
  logic [19:0] disp [11];
  int          st;
  bit          hs_q, vs_q, prev_ok, last_lock, last_exp_lock;
  int          cnt_v, cnt_s, cnt_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (row %0d col %0d frame %0d)", name, act, exp, pr, pc, fi);
    end
  endtask

  function automatic logic [3:0] lookup(input logic [19:0] p);
    for (int k = 0; k < 11; k++) if (GLYPH[k] == p) return 4'(k);
    return 4'hF;
  endfunction

  function automatic bit pixel_lit(input int c, input int y);
    int d, x, yy;
    if (c < 75 || y < 105) return 1'b0;
    if ((c - 75) % 10 != 0 || (y - 105) % 10 != 0) return 1'b0;
    d  = (c - 75) / 40;
    x  = ((c - 75) % 40) / 10;
    yy = (y - 105) / 10;
    if (d > 10 || yy > 4) return 1'b0;
    return disp[d][x + 4 * yy];
  endfunction

  task automatic build_disp();
    for (int d = 0; d < 11; d++) disp[d] = GLYPH[cur_codes[4*d +: 4]];
    if (cur_fault == F_CORRUPT) disp[0][0] = ~disp[0][0];
    for (int d = 0; d < 11; d++)
      frame_exp[4*d +: 4] = lookup(cur_fault == F_BZERO ? 20'h0 : disp[d]);
  endtask

  task automatic load_frame(input int f);
    frame_t t;
    t = tbl[f];
    cur_fault = t.fault;
    if (t.rnd) begin
      for (int d = 0; d < 11; d++) cur_codes[4*d +: 4] = 4'($urandom_range(0, 10));
    end else if (!t.same) begin
      cur_codes = t.codes;
    end
    build_disp();
  endtask

  task automatic drive();
    bit shifted;
    int v;
    shifted = (cur_fault == F_SHIFT) && (pr == 200);
    h_sync  = shifted ? (pc >= 659 && pc <= 754) : (pc >= 656 && pc <= 751);
    v_sync  = (pr == 491 || pr == 492);
    if (pixel_lit(pc - 1, pr)) begin
      {r, g, b} = 3'b111;
    end else begin
      v = $urandom_range(0, 6);
      {r, g, b} = 3'(v);
    end
    if (cur_fault == F_BZERO) b = 1'b0;
  endtask

  function automatic bit has_bad(input logic [43:0] c);
    for (int d = 0; d < 11; d++) if (c[4*d +: 4] == 4'hF) return 1'b1;
    return 1'b0;
  endfunction

  // Model of one observed cycle: inputs at (pr,pc) were captured by the edge just passed.
  task automatic observe();
    bit hr, vr, exp_v, exp_s, exp_d, exp_lock;
    exp_v = 1'b0;
    exp_s = 1'b0;
    exp_d = 1'b0;
    if (!rst_n) begin
      st = 0; hs_q = 1'b0; vs_q = 1'b0; exp_data = '0; prev_ok = 1'b0;
    end else begin
      hr = h_sync && !hs_q;
      vr = v_sync && !vs_q;
      if (st != 0)
        exp_s = (hr && pc != 656) || (h_sync && (pc < 656 || pc > 751)) ||
                (vr && !(pr == 491 && pc == 0));
      if (st == 2 && pr == 150 && pc == 0) begin
        exp_d = has_bad(frame_exp);
        if (!exp_s) begin
`ifdef VGA_DEC_STABLE_FILTER_EN
          exp_v      = prev_ok && (frame_exp == prev_codes) && !exp_d;
          prev_codes = frame_exp;
          prev_ok    = 1'b1;
`else
          exp_v = 1'b1;
`endif
          if (exp_v) exp_data = frame_exp;
        end
      end
      if (exp_s) begin
        st = 0;
        prev_ok = 1'b0;
      end else if (vr && st < 2) begin
        st++;
      end
      hs_q = h_sync;
      vs_q = v_sync;
    end
    exp_lock = (st == 2);
    if (num_valid || exp_v) check("num_valid", 64'(num_valid), 64'(exp_v));
    if (exp_v) check("num_data", 64'(num_data), 64'(exp_data));
    if (sync_err || exp_s) check("sync_err", 64'(sync_err), 64'(exp_s));
    if (decode_err || exp_d) check("decode_err", 64'(decode_err), 64'(exp_d));
    if (locked != last_lock || exp_lock != last_exp_lock)
      check("locked", 64'(locked), 64'(exp_lock));
    last_lock     = locked;
    last_exp_lock = exp_lock;
    cnt_v += int'(num_valid);
    cnt_s += int'(sync_err);
    cnt_d += int'(decode_err);
  endtask

  task automatic frame_end();
    if (fi >= 0) begin
`ifdef VGA_DEC_STABLE_FILTER_EN
      check("frame_valid_count", 64'(cnt_v), 64'(tbl[fi].v_f));
`else
      check("frame_valid_count", 64'(cnt_v), 64'(tbl[fi].v_nf));
`endif
      check("frame_sync_err_count", 64'(cnt_s), 64'(tbl[fi].n_serr));
      check("frame_decode_err_count", 64'(cnt_d), 64'(tbl[fi].n_derr));
      check("frame_num_data", 64'(num_data), 64'(exp_data));
    end
    cnt_v = 0;
    cnt_s = 0;
    cnt_d = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_num_data"}, 64'(num_data), 64'h0);
    check({tag, "_num_valid"}, 64'(num_valid), 64'h0);
    check({tag, "_locked"}, 64'(locked), 64'h0);
    check({tag, "_sync_err"}, 64'(sync_err), 64'h0);
    check({tag, "_decode_err"}, 64'(decode_err), 64'h0);
  endtask

  initial begin
    //            codes               rnd same fault      v_nf v_f serr derr
    tbl[0]  = '{44'h0123456789A,     0, 0, F_NONE,    0, 0, 0, 0};
    tbl[1]  = '{44'h0123456789A,     0, 0, F_SHIFT,   1, 0, 1, 0};
    tbl[2]  = '{44'h0,               1, 0, F_NONE,    0, 0, 0, 0};
    tbl[3]  = '{44'h0,               1, 0, F_NONE,    1, 0, 0, 0};
    tbl[4]  = '{44'h0,               0, 1, F_NONE,    1, 1, 0, 0};
    tbl[5]  = '{44'h0,               0, 1, F_CORRUPT, 1, 0, 0, 1};
    tbl[6]  = '{44'h11111111111,     0, 0, F_NONE,    1, 0, 0, 0};
    tbl[7]  = '{44'h0,               0, 0, F_NONE,    1, 0, 0, 0};
    tbl[8]  = '{44'h0,               1, 0, F_BZERO,   1, 0, 0, 1};
    tbl[9]  = '{44'h0123456789A,     0, 0, F_RESET,   0, 0, 0, 0};
    tbl[10] = '{44'h0123456789A,     0, 0, F_NONE,    0, 0, 0, 0};
    tbl[11] = '{44'h0123456789A,     0, 0, F_NONE,    1, 0, 0, 0};

    rst_n = 1'b0; h_sync = 1'b0; v_sync = 1'b0; r = 1'b0; g = 1'b0; b = 1'b0;
    st = 0; hs_q = 1'b0; vs_q = 1'b0; prev_ok = 1'b0; exp_data = '0; prev_codes = '0;
    last_lock = 1'b0; last_exp_lock = 1'b0; cnt_v = 0; cnt_s = 0; cnt_d = 0; rst_hold = 0;
    cur_fault = F_NONE;
    cur_codes = 44'h0123456789A;
    build_disp();
    fi = -1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Release just before a vertical sync so the first frames lock quickly.
    pr = 485;
    pc = 0;
    drive();
    rst_n = 1'b1;

    while (!(fi == 11 && pr == 160)) begin
      @(negedge clk);
      observe();
      pc++;
      if (pc == 800) begin
        pc = 0;
        pr++;
        if (pr == 524) begin
          pr = 0;
          frame_end();
          fi++;
          load_frame(fi);
        end
      end
      drive();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end
      if (cur_fault == F_RESET && pr == 120 && pc == 300) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        rst_hold = 5;
      end
    end
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
